// File: rtl/mul32_seq_pkg.sv
// ---------------------------------------------------------------------------
// mul32_seq_pkg
// Shared definitions for the RV32M multiply sequencer.
//   XLEN / HALF        operand width and multiplier slice width
//   OP_*               in_op encodings (funct3[1:0])
//   state_t            sequencer state encoding
//   dadda_height()     row-height targets for the Dadda reduction stages
// ---------------------------------------------------------------------------
package mul32_seq_pkg;

    localparam int XLEN = 32;
    localparam int HALF = 16;

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHSU = 2'b10;
    localparam logic [1:0] OP_MULHU  = 2'b11;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PP0  = 3'd1,
        PP1  = 3'd2,
        PP2  = 3'd3,
        PP3  = 3'd4,
        SIGN = 3'd5,
        DONE = 3'd6
    } state_t;

    // Dadda sequence d_j (13, 9, 6, 4, 3, 2) for a 16-row matrix, stage 0 first.
    function automatic int dadda_height(input int stage);
        case (stage)
            0:       return 13;
            1:       return 9;
            2:       return 6;
            3:       return 4;
            4:       return 3;
            default: return 2;
        endcase
    endfunction

endpackage

// File: rtl/mul32_seq_ctrl_dadda.sv
// ---------------------------------------------------------------------------
// MUL_using_Dadda
// 16x16 unsigned combinational multiplier. The 16 partial-product rows are
// reduced with 3:2 compressors stage by stage to the Dadda heights
// 13/9/6/4/3/2, then the last two rows are summed by one carry-propagate add.
// Ports:
//   a_i [15:0]  multiplicand
//   b_i [15:0]  multiplier
//   p_o [31:0]  product a_i * b_i
// ---------------------------------------------------------------------------
module MUL_using_Dadda
    import mul32_seq_pkg::*;
(
    input  logic [HALF-1:0]   a_i,
    input  logic [HALF-1:0]   b_i,
    output logic [2*HALF-1:0] p_o
);

    always_comb begin
        logic [2*HALF-1:0] rows [HALF];
        logic [2*HALF-1:0] nxt  [HALF];
        logic [2*HALF-1:0] x, y, z;
        int                n;
        int                k;
        int                target;

        for (int i = 0; i < HALF; i++) begin
            rows[4'(i)] = b_i[4'(i)] ? ({{HALF{1'b0}}, a_i} << i) : '0;
        end
        n = HALF;

        for (int s = 0; s < 6; s++) begin
            target = dadda_height(s);
            k      = (n > target) ? (n - target) : 0;
            for (int j = 0; j < HALF; j++) begin
                nxt[4'(j)] = '0;
            end
            // k compressors consume rows 0..3k-1 and emit 2k rows.
            for (int c = 0; c < 5; c++) begin
                if (c < k) begin
                    x = rows[4'(3*c)];
                    y = rows[4'(3*c+1)];
                    z = rows[4'(3*c+2)];
                    nxt[4'(2*c)]   = x ^ y ^ z;
                    nxt[4'(2*c+1)] = ((x & y) | (x & z) | (y & z)) << 1;
                end
            end
            // Untouched rows slide down behind the compressor outputs.
            for (int i = 0; i < HALF; i++) begin
                if ((i >= 3*k) && (i < n)) begin
                    nxt[4'(i-k)] = rows[4'(i)];
                end
            end
            for (int j = 0; j < HALF; j++) begin
                rows[4'(j)] = nxt[4'(j)];
            end
            n = target;
        end

        p_o = rows[0] + rows[1];
    end

endmodule

// File: rtl/mul32_seq_ctrl.sv
// ---------------------------------------------------------------------------
// mul32_seq_ctrl
// Multi-cycle RV32M multiply sequencer (MUL/MULH/MULHSU/MULHU). One shared
// 16x16 Dadda multiplier produces four partial products that are accumulated
// into a 64-bit register; a final step applies the sign and selects rd.
// Optional build macro: MUL_EARLY_OUT_EN - skip partial products whose upper
// operand half is zero (latency 2..5 instead of a fixed 5).
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid/in_ready     request handshake (in_ready high only in IDLE)
//   in_op [1:0]           00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//   in_rs1/in_rs2 [31:0]  operands
//   flush                 abort any in-flight operation, no result
//   out_valid/out_ready   result handshake
//   out_result [31:0]     rd value
//
// state | meaning
// IDLE  | waiting for a request, in_ready high
// PP0   | acc += aL*bL
// PP1   | acc += aL*bH << 16
// PP2   | acc += aH*bL << 16
// PP3   | acc += aH*bH << 32
// SIGN  | conditional 64-bit negate, register rd word
// DONE  | out_valid high until out_ready
// ---------------------------------------------------------------------------
module mul32_seq_ctrl
    import mul32_seq_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      in_op,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result
);

    state_t              state_q;
    logic [XLEN-1:0]     a_q, b_q;
    logic [1:0]          op_q;
    logic                neg_q;
    logic                skip_ah_q, skip_bh_q;
    logic [2*XLEN-1:0]   acc_q;
    logic [XLEN-1:0]     result_q;
    logic                out_valid_q;
    logic                in_ready_q;

    // Operand conditioning at accept
    logic                rs1_neg, rs2_neg;
    logic [XLEN-1:0]     a_mag_d, b_mag_d;
    logic                skip_ah_d, skip_bh_d;

    assign rs1_neg = ((in_op == OP_MULH) || (in_op == OP_MULHSU)) && in_rs1[XLEN-1];
    assign rs2_neg = (in_op == OP_MULH) && in_rs2[XLEN-1];
    // 0x80000000 negates to itself, which read unsigned is the required 2^31.
    assign a_mag_d = rs1_neg ? (~in_rs1 + 32'd1) : in_rs1;
    assign b_mag_d = rs2_neg ? (~in_rs2 + 32'd1) : in_rs2;

`ifdef MUL_EARLY_OUT_EN
    assign skip_ah_d = (a_mag_d[XLEN-1:HALF] == '0);
    assign skip_bh_d = (b_mag_d[XLEN-1:HALF] == '0);
`else
    assign skip_ah_d = 1'b0;
    assign skip_bh_d = 1'b0;
`endif

    // Shared multiplier and its input mux
    logic [HALF-1:0]     mul_a, mul_b;
    logic [2*HALF-1:0]   mul_p;
    logic [2*XLEN-1:0]   addend;

    always_comb begin
        mul_a  = '0;
        mul_b  = '0;
        addend = '0;
        case (state_q)
            PP0: begin
                mul_a  = a_q[HALF-1:0];
                mul_b  = b_q[HALF-1:0];
                addend = {32'd0, mul_p};
            end
            PP1: begin
                mul_a  = a_q[HALF-1:0];
                mul_b  = b_q[XLEN-1:HALF];
                addend = {16'd0, mul_p, 16'd0};
            end
            PP2: begin
                mul_a  = a_q[XLEN-1:HALF];
                mul_b  = b_q[HALF-1:0];
                addend = {16'd0, mul_p, 16'd0};
            end
            PP3: begin
                mul_a  = a_q[XLEN-1:HALF];
                mul_b  = b_q[XLEN-1:HALF];
                addend = {mul_p, 32'd0};
            end
            default: ;
        endcase
    end

    MUL_using_Dadda u_dadda (
        .a_i (mul_a),
        .b_i (mul_b),
        .p_o (mul_p)
    );

    // Next partial-product state; bH==0 kills PP1/PP3, aH==0 kills PP2/PP3.
    state_t pp_next_d;

    always_comb begin
        pp_next_d = SIGN;
        case (state_q)
            PP0:     pp_next_d = !skip_bh_q ? PP1 : (!skip_ah_q ? PP2 : SIGN);
            PP1:     pp_next_d = !skip_ah_q ? PP2 : SIGN;
            PP2:     pp_next_d = !skip_bh_q ? PP3 : SIGN;
            default: pp_next_d = SIGN;
        endcase
    end

    logic [2*XLEN-1:0] acc_fin_d;
    assign acc_fin_d = neg_q ? (~acc_q + 64'd1) : acc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= OP_MUL;
            neg_q       <= 1'b0;
            skip_ah_q   <= 1'b0;
            skip_bh_q   <= 1'b0;
            acc_q       <= '0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else if (flush) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        a_q        <= a_mag_d;
                        b_q        <= b_mag_d;
                        op_q       <= in_op;
                        neg_q      <= rs1_neg ^ rs2_neg;
                        skip_ah_q  <= skip_ah_d;
                        skip_bh_q  <= skip_bh_d;
                        acc_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= PP0;
                    end
                end
                PP0, PP1, PP2, PP3: begin
                    acc_q   <= acc_q + addend;
                    state_q <= pp_next_d;
                end
                SIGN: begin
                    acc_q       <= acc_fin_d;
                    result_q    <= (op_q == OP_MUL) ? acc_fin_d[XLEN-1:0]
                                                    : acc_fin_d[2*XLEN-1:XLEN];
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_result = result_q;

endmodule

// File: tb/tb_mul32_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mul32_seq_ctrl
// Directed bench for mul32_seq_ctrl with a result/latency scoreboard.
// ---------------------------------------------------------------------------
module tb_mul32_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [31:0] in_rs1;
    logic [31:0] in_rs2;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q[$];
    int          lat_q[$];

    always #5 clk = ~clk;

    mul32_seq_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result)
    );

    // Reference: sign/zero-extend to 66 bits and multiply directly.
    function automatic logic [31:0] model_res(input logic [1:0] op,
                                              input logic [31:0] r1,
                                              input logic [31:0] r2);
        logic signed [65:0] x, y, p;
        x = (op == 2'b01 || op == 2'b10) ? {{34{r1[31]}}, r1} : {34'd0, r1};
        y = (op == 2'b01) ? {{34{r2[31]}}, r2} : {34'd0, r2};
        p = x * y;
        return (op == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    function automatic int model_lat(input logic [1:0] op,
                                     input logic [31:0] r1,
                                     input logic [31:0] r2);
`ifdef MUL_EARLY_OUT_EN
        logic [31:0] a, b;
        int ah, bh;
        a  = ((op == 2'b01 || op == 2'b10) && r1[31]) ? (32'd0 - r1) : r1;
        b  = ((op == 2'b01) && r2[31]) ? (32'd0 - r2) : r2;
        ah = (a[31:16] != 16'd0) ? 1 : 0;
        bh = (b[31:16] != 16'd0) ? 1 : 0;
        return 2 + ah + bh + ah * bh;
`else
        return 5;
`endif
    endfunction

    task automatic chk32(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [1:0] op, input logic [31:0] r1, input logic [31:0] r2);
        exp_q.push_back(model_res(op, r1, r2));
        lat_q.push_back(model_lat(op, r1, r2));
    endtask

    // Presents a request for one edge (the accept edge when in IDLE).
    task automatic issue(input logic [1:0] op, input logic [31:0] r1,
                         input logic [31:0] r2, input bit track);
        chk32("in_ready_idle", {31'd0, in_ready}, 32'd1);
        if (track) push_exp(op, r1, r2);
        in_op    = op;
        in_rs1   = r1;
        in_rs2   = r2;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk32("in_ready_busy", {31'd0, in_ready}, 32'd0);
    endtask

    // Called right after the accept edge; waits for out_valid and scores it.
    task automatic collect();
        int cyc;
        logic [31:0] e;
        int l;
        cyc = 0;
        while (!out_valid && cyc < 30) begin
            tick();
            cyc++;
        end
        chk32("out_valid_seen", {31'd0, out_valid}, 32'd1);
        if (exp_q.size() == 0) begin
            chk_int("scoreboard_nonempty", 0, 1);
        end else begin
            e = exp_q.pop_front();
            l = lat_q.pop_front();
            chk32("result", out_result, e);
            chk_int("latency", cyc, l);
            chk32("in_ready_done", {31'd0, in_ready}, 32'd0);
        end
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] r1, input logic [31:0] r2);
        issue(op, r1, r2, 1'b1);
        collect();
        tick();
        chk32("out_valid_drop", {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_op     = 2'b00;
        in_rs1    = '0;
        in_rs2    = '0;
        flush     = 1'b0;
        out_ready = 1'b1;
        repeat (3) tick();
        chk32("rst_in_ready",   {31'd0, in_ready},  32'd1);
        chk32("rst_out_valid",  {31'd0, out_valid}, 32'd0);
        chk32("rst_out_result", out_result,         32'd0);
        rst = 1'b0;
        tick();

        // Directed arithmetic cases
        run_op(2'b00, 32'h0000_0007, 32'hFFFF_FFFD);
        run_op(2'b01, 32'h8000_0000, 32'h8000_0000);
        run_op(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(2'b10, 32'h0000_0002, 32'h8000_0000);
        run_op(2'b11, 32'h0000_FFFF, 32'h0000_FFFF);
        run_op(2'b01, 32'hFFFF_FFF9, 32'h0001_2345);
        run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(2'b01, 32'h0000_0000, 32'h8765_4321);

        // Backpressure: result held 10 clocks, next request accepted after release
        out_ready = 1'b0;
        issue(2'b00, 32'h0000_1234, 32'h0000_0010, 1'b1);
        collect();
        for (int i = 0; i < 10; i++) begin
            tick();
            chk32("hold_valid",  {31'd0, out_valid}, 32'd1);
            chk32("hold_result", out_result,         32'h0001_2340);
            chk32("hold_ready",  {31'd0, in_ready},  32'd0);
        end
        push_exp(2'b11, 32'hDEAD_BEEF, 32'h1234_5678);
        in_op     = 2'b11;
        in_rs1    = 32'hDEAD_BEEF;
        in_rs2    = 32'h1234_5678;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        chk32("release_in_ready",  {31'd0, in_ready},  32'd1);
        chk32("release_out_valid", {31'd0, out_valid}, 32'd0);
        tick();
        in_valid = 1'b0;
        chk32("accept_after_release", {31'd0, in_ready}, 32'd0);
        collect();
        tick();

        // Flush in PP2 (operands keep every PP state in both builds)
        issue(2'b11, 32'h1234_5678, 32'h9ABC_DEF1, 1'b0);
        tick();
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk32("flush_in_ready",  {31'd0, in_ready},  32'd1);
        chk32("flush_out_valid", {31'd0, out_valid}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk32("flush_no_result", {31'd0, out_valid}, 32'd0);
        end

        // Request presented together with flush is ignored
        in_op    = 2'b00;
        in_rs1   = 32'h0000_0003;
        in_rs2   = 32'h0000_0005;
        in_valid = 1'b1;
        flush    = 1'b1;
        tick();
        in_valid = 1'b0;
        flush    = 1'b0;
        chk32("flush_blocks_accept", {31'd0, in_ready}, 32'd1);
        for (int i = 0; i < 7; i++) begin
            tick();
            chk32("flush_accept_no_result", {31'd0, out_valid}, 32'd0);
        end

        // Reset while in DONE
        out_ready = 1'b0;
        issue(2'b00, 32'h0000_0003, 32'h0000_0005, 1'b1);
        collect();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk32("rstdone_out_valid",  {31'd0, out_valid}, 32'd0);
        chk32("rstdone_out_result", out_result,         32'd0);
        chk32("rstdone_in_ready",   {31'd0, in_ready},  32'd1);
        out_ready = 1'b1;
        tick();

        // Random mix
        for (int i = 0; i < 10; i++) begin
            logic [1:0]  op;
            logic [31:0] r1, r2;
            op = 2'($urandom_range(0, 3));
            r1 = $urandom;
            r2 = $urandom;
            if (i % 3 == 0) r1 = r1 & 32'h0000_FFFF;
            if (i % 4 == 1) r2 = r2 & 32'h0000_FFFF;
            run_op(op, r1, r2);
        end

        chk_int("scoreboard_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
